// File: rtl/piso_tx.sv
// piso_tx: parallel-in serial-out transmitter.
// Accepts a WIDTH-bit word on load && ready and shifts it out MSB first,
// one bit per clock, with out_valid framing and a last strobe on the
// final bit. Back-to-back words follow with no idle gap.
// Optional feature macro: PARITY_EN appends an even-parity bit (PAR state)
// after bit 0; last and ready then move to that parity cycle.
// Handshake: a word is taken on a rising clk edge where load && ready;
// ready is combinational from state/counter and does not depend on load.
module piso_tx #(
  parameter  int WIDTH = 4,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             load,
  output logic             ready,
  output logic             out,
  output logic             out_valid,
  output logic             last,
  output logic             busy
);

`ifdef PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

  state_t             state, state_n;
  logic [WIDTH-1:0]   sreg, sreg_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               out_n, valid_n, last_n;
  logic               accept;
  logic               do_start, do_stop;
`ifdef PARITY_EN
  logic               par_q, par_n;
`endif

  // Ready: always in IDLE, otherwise only in the final cycle of a frame.
  always_comb begin
    ready = 1'b0;
    case (state)
      IDLE:  ready = 1'b1;
`ifdef PARITY_EN
      SHIFT: ready = 1'b0;
      PAR:   ready = 1'b1;
`else
      SHIFT: ready = (cnt == CNT_W'(WIDTH));
`endif
      default: ready = 1'b0;
    endcase
  end

  assign accept = load && ready;
  assign busy   = (state != IDLE);

  // Next-state and next-output logic; start/stop flags share the frame
  // boundary handling between IDLE, the bit-0 cycle and the parity cycle.
  always_comb begin
    state_n  = state;
    sreg_n   = sreg;
    cnt_n    = cnt;
    out_n    = out;
    valid_n  = out_valid;
    last_n   = last;
    do_start = 1'b0;
    do_stop  = 1'b0;
`ifdef PARITY_EN
    par_n    = par_q;
`endif
    case (state)
      IDLE: begin
        if (accept) do_start = 1'b1;
      end
      SHIFT: begin
        if (cnt != CNT_W'(WIDTH)) begin
          // The next lower bit sits at WIDTH-2 because sreg shifts left.
          out_n  = sreg[WIDTH-2];
          sreg_n = sreg << 1;
          cnt_n  = cnt + CNT_W'(1);
`ifdef PARITY_EN
          last_n = 1'b0;
`else
          last_n = (cnt == CNT_W'(WIDTH - 1));
`endif
        end else begin
`ifdef PARITY_EN
          state_n = PAR;
          out_n   = par_q;
          valid_n = 1'b1;
          last_n  = 1'b1;
`else
          if (accept) do_start = 1'b1;
          else        do_stop  = 1'b1;
`endif
        end
      end
`ifdef PARITY_EN
      PAR: begin
        if (accept) do_start = 1'b1;
        else        do_stop  = 1'b1;
      end
`endif
      default: begin
        do_stop = 1'b1;
      end
    endcase

    if (do_start) begin
      state_n = SHIFT;
      sreg_n  = din;
      out_n   = din[WIDTH-1];
      valid_n = 1'b1;
      last_n  = 1'b0;
      cnt_n   = CNT_W'(1);
`ifdef PARITY_EN
      par_n   = ^din;
`endif
    end else if (do_stop) begin
      state_n = IDLE;
      out_n   = 1'b0;
      valid_n = 1'b0;
      last_n  = 1'b0;
      cnt_n   = '0;
    end
  end

  // State and registered outputs; reset aborts any frame immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sreg      <= '0;
      cnt       <= '0;
      out       <= 1'b0;
      out_valid <= 1'b0;
      last      <= 1'b0;
`ifdef PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      sreg      <= sreg_n;
      cnt       <= cnt_n;
      out       <= out_n;
      out_valid <= valid_n;
      last      <= last_n;
`ifdef PARITY_EN
      par_q     <= par_n;
`endif
    end
  end

endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx: directed and random stimulus for piso_tx, checked against a
// bit-queue model of the serial frame. Honors PARITY_EN like the design.
module tb_piso_tx;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] din = '0;
  logic         load = 1'b0;
  logic         ready, out, out_valid, last, busy;

  int n_assert = 0;
  int n_fail   = 0;

  // Model: current output bit plus the queue of bits still to come.
  bit m_out, m_valid, m_last;
  bit fq[$];
  logic [15:0] cap;

  piso_tx #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .din(din), .load(load),
    .ready(ready), .out(out), .out_valid(out_valid), .last(last), .busy(busy)
  );

  // Clock
  always #5 clk = ~clk;

  function automatic bit m_ready();
    return !m_valid || m_last;
  endfunction

  function automatic void model_clear();
    fq.delete();
    m_out = 0; m_valid = 0; m_last = 0;
  endfunction

  // One clock edge of the model, given the inputs seen at that edge.
  function automatic void model_edge(bit l, logic [W-1:0] d);
    if (l && m_ready()) begin
      fq.delete();
      for (int i = W - 1; i >= 0; i--) fq.push_back(d[i]);
`ifdef PARITY_EN
      fq.push_back(^d);
`endif
      m_out   = fq.pop_front();
      m_valid = 1;
      m_last  = (fq.size() == 0);
    end else if (fq.size() > 0) begin
      m_out  = fq.pop_front();
      m_last = (fq.size() == 0);
    end else begin
      m_out = 0; m_valid = 0; m_last = 0;
    end
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".out"},       16'(out),       16'(m_out));
    check({tag, ".out_valid"}, 16'(out_valid), 16'(m_valid));
    check({tag, ".last"},      16'(last),      16'(m_last));
    check({tag, ".busy"},      16'(busy),      16'(m_valid));
    check({tag, ".ready"},     16'(ready),     16'(m_ready()));
  endtask

  // Drive one cycle of inputs, check current outputs, advance the model.
  task automatic step(input string tag, input bit l, input logic [W-1:0] d);
    @(negedge clk);
    load = l;
    din  = d;
    #1;
    check_all(tag);
    if (out_valid) cap = {cap[14:0], out};
    @(posedge clk);
    model_edge(l, d);
  endtask

  // Raise rst between edges with load high; outputs must clear at once.
  task automatic do_reset(input string tag);
    @(negedge clk);
    #2;
    load = 1'b1;
    din  = W'($urandom);
    rst  = 1'b1;
    #1;
    model_clear();
    check_all({tag, ".async"});
    repeat (2) @(posedge clk);
    #1;
    check_all({tag, ".held"});
    @(negedge clk);
    rst  = 1'b0;
    load = 1'b0;
  endtask

  initial begin
    model_clear();
    cap = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_all("por");

    // Reset asserted mid-clock from idle
    do_reset("rst_idle");

    // Single word 1101
    cap = '0;
    step("single", 1, 4'b1101);
    for (int i = 0; i < W + 2; i++) step("single", 0, 4'b0000);
`ifdef PARITY_EN
    check("single.stream", cap, 16'b11011);
`else
    check("single.stream", cap, 16'b1101);
`endif

    // Back-to-back 1110 then 0101 with load held
    cap = '0;
    step("b2b", 1, 4'b1110);
    for (int i = 0; i < W - 1; i++) step("b2b", 1, 4'b1110);
`ifdef PARITY_EN
    step("b2b", 1, 4'b1110);
`endif
    step("b2b", 1, 4'b0101);
    for (int i = 0; i < W + 2; i++) step("b2b", 0, 4'b0101);
`ifdef PARITY_EN
    check("b2b.stream", cap, 16'b1110101010);
`else
    check("b2b.stream", cap, 16'b11100101);
`endif

    // Load while busy is ignored
    cap = '0;
    step("busy_ld", 1, 4'b1000);
    step("busy_ld", 0, 4'b1000);
    step("busy_ld", 1, 4'b1111);
    for (int i = 0; i < W + 1; i++) step("busy_ld", 0, 4'b1111);
`ifdef PARITY_EN
    check("busy_ld.stream", cap, 16'b10001);
`else
    check("busy_ld.stream", cap, 16'b1000);
`endif

    // Reset mid-frame, then a clean word
    step("abort", 1, 4'b1011);
    step("abort", 0, 4'b1011);
    do_reset("abort_rst");
    cap = '0;
    step("after", 1, 4'b0110);
    for (int i = 0; i < W + 2; i++) step("after", 0, 4'b0000);
`ifdef PARITY_EN
    check("after.stream", cap, 16'b01100);
    cap = '0;
    step("par0", 1, 4'b1001);
    for (int i = 0; i < W + 1; i++) step("par0", 0, 4'b0000);
    check("par0.stream", cap, 16'b10010);
`else
    check("after.stream", cap, 16'b0110);
`endif

    // Random traffic with occasional mid-frame resets
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) do_reset("rnd_rst");
      else step("rnd", $urandom_range(0, 3) != 0, W'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/piso_tx.md
Name: piso_tx

Overview:
Parallel-in serial-out transmitter: the sending end of the serial bit stream consumed by the SISO shift-register chain. Accepts a WIDTH-bit word over a valid/ready handshake and drives it MSB-first, one bit per clock, with a framing strobe. Supports back-to-back words with no idle gap. Sits between a parallel data source and any downstream serial consumer (SISO/SIPO register).

Parameters:
WIDTH, 4, word length in bits (>=2)
CNT_W, $clog2(WIDTH+1), bit-counter width (derived, not overridden)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
din  input  WIDTH  parallel word to send
load  input  1  source valid; word accepted on rising edge where load && ready
ready  output  1  block can accept a word this cycle (combinational from state/counter)
out  output  1  serial data bit, registered
out_valid  output  1  high while out carries a frame bit, registered
last  output  1  high while out carries the final bit of a frame, registered
busy  output  1  high while state != IDLE

Behaviour:
- One clock domain (clk). Reset is asynchronous and active-high (rst); it applies immediately, independent of clk.
- Reset values: state=IDLE, shift reg=0, counter=0, out=0, out_valid=0, last=0, busy=0. After reset, ready=1.
- States: IDLE, SHIFT (PAR added with PARITY_EN).
- IDLE: ready=1. On an accept edge: load shift reg with din, out<=din[WIDTH-1], out_valid<=1, counter<=1, state->SHIFT. With no accept, out and out_valid stay 0.
- SHIFT: each edge drives the next lower bit on out and increments counter. last=1 while bit 0 is on out.
- ready=1 in SHIFT only during the cycle bit 0 is on out.
- Accept during that last-bit cycle: the new word's MSB appears on the next edge. No gap; out_valid stays 1.
- No accept at frame end: state->IDLE, out<=0, out_valid<=0, last<=0.
- Latency: MSB on out one edge after accept. Frame is WIDTH cycles, exactly one bit per clock, MSB first.
- load while ready=0 is ignored. Word not captured; no error flag. The source must hold load/din until accepted.
- din is sampled only on the accept edge. Later changes to din do not affect a frame in progress.
- Counter never exceeds WIDTH. It returns to 1 on a back-to-back accept.
- rst asserted mid-frame: frame is aborted at once and all outputs go to reset values. There is no resumption; the partial frame is lost.
- If rst and load are high together, rst wins and nothing is accepted.

Optional Feature:
PARITY_EN:
- Defined: after bit 0, one extra cycle in state PAR drives the even-parity bit (XOR of the word) on out, with out_valid=1.
- last moves to the parity cycle. ready=1 in the PAR cycle instead of the bit-0 cycle. Frame length is WIDTH+1.
- Undefined: no PAR state; behaviour exactly as above.

Test Plan:
1. Reset: assert rst mid-clock for 2 cycles -> out=0, out_valid=0, busy=0, ready=1 immediately on rst rise, without waiting for a clock edge.
2. Single word: din=4'b1101, load one cycle in IDLE -> out=1,1,0,1 on the next 4 edges; out_valid=1 for 4 cycles; last=1 on the 4th; then IDLE, ready=1.
3. Back-to-back: 4'b1110 then 4'b0101, load held high -> out=1,1,1,0,0,1,0,1 with out_valid continuous for 8 cycles; ready high only in cycles 4 and 8.
4. Load while busy: accept 4'b1000, then pulse load with din=4'b1111 in bit cycle 2 -> ignored; out=1,0,0,0, then idle.
5. Reset mid-frame: accept 4'b1011, assert rst after 2 bits -> outputs 0 immediately. Next word 4'b0110 after release -> out=0,1,1,0 cleanly.
6. (PARITY_EN) din=4'b1101 -> out=1,1,0,1,1 over 5 cycles, last on the 5th. din=4'b1001 -> parity bit 0.
